// File: rtl/sdram_word_bridge_pkg.sv
// sdram_word_bridge_pkg: shared state encoding, default error word and halfword helpers for the SDRAM word bridge
package sdram_word_bridge_pkg;
  typedef enum logic [2:0] {IDLE, RD_ISS, RD_WAIT, WR_ISS, WR_WAIT, DONE} state_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam logic H_LO = 1'b0;
  localparam logic H_HI = 1'b1;
  // a fully strobed half is written directly, a partial one needs a read first
  function automatic state_t half_op(input logic [1:0] s);
    return s == 2'b11 ? WR_ISS : RD_ISS;
  endfunction
endpackage

// File: rtl/sdram_word_bridge_if.sv
// sdram_word_bridge_if: PicoRV32 native bus (valid/sel/addr/wdata/wstrb in, ready/rdata back); master = CPU, slave = bridge
interface sdram_word_bridge_if;
  logic        mem_valid;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master (output mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave (input mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/sdram_word_bridge_tmo.sv
// sdram_word_bridge_tmo: per-op cycle counter; clr restarts it, run counts, expired flags the TIMEOUT-th cycle (TIMEOUT=0 never expires)
module sdram_word_bridge_tmo #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = TIMEOUT != 0 && run && cnt_q == W'(TIMEOUT - 1);
  always_comb cnt_d = clr ? '0 : run && !expired ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge: splits 32-bit CPU accesses into low/high 16-bit controller ops, byte writes via read-modify-write
//   bus          CPU native bus (slave modport)
//   sd_*         sdram_controller host port: halfword addr, write data, rd/wr enable pulses, read data/strobe, busy
//   bridge_busy  high outside IDLE;  timeout_err  one-cycle pulse on an abandoned op
module sdram_word_bridge
  import sdram_word_bridge_pkg::*;
#(
  parameter int          HADDR_W  = 22,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  sdram_word_bridge_if.slave bus,
  output logic [HADDR_W-1:0] sd_wr_addr,
  output logic [15:0]        sd_wr_data,
  output logic               sd_wr_enable,
  output logic [HADDR_W-1:0] sd_rd_addr,
  output logic               sd_rd_enable,
  input  logic [15:0]        sd_rd_data,
  input  logic               sd_rd_ready,
  input  logic               sd_busy,
  output logic               bridge_busy,
  output logic               timeout_err
);
  state_t state_q, state_d;
  logic [HADDR_W-2:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [15:0] wbuf_q, wbuf_d, wh;
  logic [1:0] hs;
  logic h_q, h_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d, seen_q, seen_d, terr_q, terr_d;
  logic tmo_exp, tmo_clr, tmo_run, unused_addr;
  function automatic logic [15:0] merge_half(input logic [1:0] s, input logic [15:0] w, input logic [15:0] r);
    return {s[1] ? w[15:8] : r[15:8], s[0] ? w[7:0] : r[7:0]};
  endfunction
  assign hs = h_q ? wstrb_q[3:2] : wstrb_q[1:0];
  assign wh = h_q ? wdata_q[31:16] : wdata_q[15:0];
  assign tmo_run = state_q inside {RD_ISS, RD_WAIT, WR_ISS, WR_WAIT};
  assign tmo_clr = (state_d == RD_ISS || state_d == WR_ISS) && state_d != state_q;
  sdram_word_bridge_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk), .reset_n(reset_n), .clr(tmo_clr), .run(tmo_run), .expired(tmo_exp)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rbuf_d  = rbuf_q;
    wbuf_d  = wbuf_q;
    h_d     = h_q;
    seen_d  = seen_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.mem_valid && bus.mem_sel) begin
        addr_d  = bus.mem_addr[HADDR_W:2];
        wdata_d = bus.mem_wdata;
        wstrb_d = bus.mem_wstrb;
        // a write with no low strobes starts on the high half
        h_d     = bus.mem_wstrb[1:0] == 2'b00 && bus.mem_wstrb != 4'b0000 ? H_HI : H_LO;
        state_d = bus.mem_wstrb == 4'b0000 ? RD_ISS : half_op(h_d ? bus.mem_wstrb[3:2] : bus.mem_wstrb[1:0]);
      end
      RD_ISS: if (!sd_busy) begin
        rd_en_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (sd_rd_ready) begin
        rbuf_d  = h_q ? {sd_rd_data, rbuf_q[15:0]} : {rbuf_q[31:16], sd_rd_data};
        wbuf_d  = merge_half(hs, wh, sd_rd_data);
        h_d     = wstrb_q == 4'b0000 ? H_HI : h_q;
        state_d = wstrb_q != 4'b0000 ? WR_ISS : h_q ? DONE : RD_ISS;
      end
      WR_ISS: if (!sd_busy) begin
        wr_en_d = 1'b1;
        seen_d  = 1'b0;
        wbuf_d  = hs == 2'b11 ? wh : wbuf_q;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        // the write is only finished once busy has been observed and then released
        seen_d = seen_q | sd_busy;
        if (seen_q && !sd_busy) begin
          h_d     = H_HI;
          state_d = !h_q && wstrb_q[3:2] != 2'b00 ? half_op(wstrb_q[3:2]) : DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a completing op wins over a coincident expiry
    if (tmo_exp && state_d == state_q) begin
      state_d = DONE;
      terr_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      h_q     <= H_LO;
      seen_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rbuf_q  <= rbuf_d;
      wbuf_q  <= wbuf_d;
      h_q     <= h_d;
      seen_q  <= seen_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      terr_q  <= terr_d;
    end
  assign sd_rd_addr    = {addr_q, h_q};
  assign sd_wr_addr    = {addr_q, h_q};
  assign sd_wr_data    = wbuf_q;
  assign sd_wr_enable  = wr_en_q;
  assign sd_rd_enable  = rd_en_q;
  assign bridge_busy   = state_q != IDLE;
  assign timeout_err   = terr_q;
  assign bus.mem_ready = state_q == DONE;
  assign bus.mem_rdata = state_q == DONE && wstrb_q == 4'b0000 ? (terr_q ? ERR_DATA : rbuf_q) : 32'h0;
  assign unused_addr   = ^{bus.mem_addr[31:HADDR_W+1], bus.mem_addr[1:0]};
endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb_sdram_word_bridge: random and directed accesses against a halfword-memory controller model with a queue scoreboard
module tb_sdram_word_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  sdram_word_bridge_if b0 ();
  sdram_word_bridge_if b1 ();
  logic [21:0] wa0, ra0, wa1, ra1;
  logic [15:0] wd0, wd1, sd_rd_data;
  logic we0, re0, we1, re1, bb0, bb1, te0, te1, sd_rd_ready, sd_busy;
  sdram_word_bridge d0 (
    .clk(clk), .reset_n(rst_n), .bus(b0),
    .sd_wr_addr(wa0), .sd_wr_data(wd0), .sd_wr_enable(we0),
    .sd_rd_addr(ra0), .sd_rd_enable(re0), .sd_rd_data(sd_rd_data),
    .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy), .bridge_busy(bb0), .timeout_err(te0)
  );
  sdram_word_bridge #(.TIMEOUT(16)) d1 (
    .clk(clk), .reset_n(rst_n), .bus(b1),
    .sd_wr_addr(wa1), .sd_wr_data(wd1), .sd_wr_enable(we1),
    .sd_rd_addr(ra1), .sd_rd_enable(re1), .sd_rd_data(sd_rd_data),
    .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy), .bridge_busy(bb1), .timeout_err(te1)
  );
  typedef struct {bit wr; int a; logic [15:0] d;} op_t;
  typedef struct {logic [31:0] d; bit te; bit t;} rsp_t;
  op_t eops[$];
  rsp_t ersp[$];
  logic [15:0] smem [64];
  logic [15:0] rmem [64];
  int n_cmp = 0;
  int n_err = 0;
  bit sel = 0;
  bit force_busy = 0;
  bit no_resp = 0;
  int lat = 2;
  logic busy_q, busy_prev, pend;
  logic [5:0] paddr;
  int bcnt;
  logic re, we;
  logic [21:0] ra, wa;
  logic [15:0] wd;
  assign sd_busy = busy_q | force_busy;
  assign re = sel ? re1 : re0;
  assign we = sel ? we1 : we0;
  assign ra = sel ? ra1 : ra0;
  assign wa = sel ? wa1 : wa0;
  assign wd = sel ? wd1 : wd0;
  task automatic report;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic chk_op(input bit w, input logic [21:0] a, input logic [15:0] d);
    op_t e;
    if (eops.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_op: got wr=%0d addr=%h want no op", w, a);
      return;
    end
    e = eops.pop_front();
    chk("op_kind", 32'(w), 32'(e.wr));
    chk("op_addr", 32'(a), 32'(e.a));
    if (w) chk("op_wdata", 32'(d), 32'(e.d));
  endtask
  task automatic chk_rsp(input bit t, input logic [31:0] d, input logic te);
    rsp_t e;
    if (ersp.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_ready: dut %0d got rdata %h want no response", t, d);
      return;
    end
    e = ersp.pop_front();
    chk("rsp_dut", 32'(t), 32'(e.t));
    chk("rdata", d, e.d);
    chk("timeout_err", 32'(te), 32'(e.te));
  endtask
  // controller model: one op at a time, busy for lat cycles, read data strobed as busy falls
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= 1'b0;
      busy_prev <= 1'b0;
      pend <= 1'b0;
      paddr <= '0;
      bcnt <= 0;
      sd_rd_ready <= 1'b0;
      sd_rd_data <= '0;
    end else begin
      busy_prev <= sd_busy;
      sd_rd_ready <= 1'b0;
      if (re || we) begin
        chk("issue_while_busy", 32'(busy_prev), 32'h0);
        chk_op(we, we ? wa : ra, wd);
        if (we) smem[wa[5:0]] <= wd;
        busy_q <= 1'b1;
        bcnt <= lat;
        pend <= re;
        paddr <= ra[5:0];
      end else if (bcnt > 1) bcnt <= bcnt - 1;
      else if (bcnt == 1) begin
        bcnt <= 0;
        busy_q <= 1'b0;
        pend <= 1'b0;
        if (pend && !no_resp) begin
          sd_rd_ready <= 1'b1;
          sd_rd_data <= smem[paddr];
        end
      end
    end
  always @(negedge clk)
    if (rst_n) begin
      if (b0.mem_ready) chk_rsp(1'b0, b0.mem_rdata, te0);
      if (b1.mem_ready) chk_rsp(1'b1, b1.mem_rdata, te1);
      if (te0 && !b0.mem_ready) chk("timeout_err_stray0", 32'(te0), 32'h0);
      if (te1 && !b1.mem_ready) chk("timeout_err_stray1", 32'(te1), 32'h0);
    end
  task automatic drive(input bit t, input logic v, input logic s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    if (t) begin
      b1.mem_valid = v; b1.mem_sel = s; b1.mem_addr = a; b1.mem_wdata = d; b1.mem_wstrb = w;
    end else begin
      b0.mem_valid = v; b0.mem_sel = s; b0.mem_addr = a; b0.mem_wdata = d; b0.mem_wstrb = w;
    end
  endtask
  // reference: a word is two halfwords; partial halves are read then rewritten, untouched halves skipped
  task automatic issue(input bit t, input logic [31:0] addr, input logic [31:0] wdat, input logic [3:0] ws);
    int lo;
    logic [15:0] nv;
    logic [1:0] s;
    lo = int'(addr[6:2]) * 2;
    if (ws == 4'b0000) begin
      eops.push_back('{1'b0, lo, 16'h0});
      eops.push_back('{1'b0, lo + 1, 16'h0});
      ersp.push_back('{{rmem[lo+1], rmem[lo]}, 1'b0, t});
    end else begin
      for (int h = 0; h < 2; h++) begin
        s = ws[2*h +: 2];
        if (s != 2'b00) begin
          if (s != 2'b11) eops.push_back('{1'b0, lo + h, 16'h0});
          nv = rmem[lo+h];
          for (int b = 0; b < 2; b++) if (ws[2*h+b]) nv[8*b +: 8] = wdat[16*h+8*b +: 8];
          eops.push_back('{1'b1, lo + h, nv});
          rmem[lo+h] = nv;
        end
      end
      ersp.push_back('{32'h0, 1'b0, t});
    end
    @(negedge clk);
    drive(t, 1'b1, 1'b1, addr, wdat, ws);
  endtask
  task automatic finish_acc(input bit t, input bit drop);
    int n = 0;
    if (drop) begin
      repeat (2) @(negedge clk);
      drive(t, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    while (!(t ? b1.mem_ready : b0.mem_ready)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        n_cmp++;
        n_err++;
        $display("FAIL access_timeout: no mem_ready after %0d cycles, want completion", n);
        report();
      end
    end
    drive(t, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time exhausted, want completion");
    report();
  end
  initial begin
    int n;
    logic [3:0] ws;
    for (int i = 0; i < 64; i++) begin
      rmem[i] = 16'($urandom);
      smem[i] <= rmem[i];
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bridge_busy", 32'(bb0), 32'h0);
    chk("rst_rd_enable", 32'(re0), 32'h0);
    chk("rst_wr_enable", 32'(we0), 32'h0);
    chk("rst_rd_addr", 32'(ra0), 32'h0);
    chk("rst_wr_data", 32'(wd0), 32'h0);
    chk("rst_mem_ready", 32'(b0.mem_ready), 32'h0);
    chk("rst_mem_rdata", b0.mem_rdata, 32'h0);
    chk("rst_timeout_err", 32'(te0), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0400_0010, 32'h0, 4'h0);
    repeat (5) @(negedge clk);
    chk("unselected_busy", 32'(bb0), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rmem[8] = 16'h1234; smem[8] <= 16'h1234;
    rmem[9] = 16'hABCD; smem[9] <= 16'hABCD;
    issue(1'b0, 32'h0400_0010, 32'h0, 4'h0);
    finish_acc(1'b0, 1'b0);
    issue(1'b0, 32'h0400_0020, 32'hCAFE_F00D, 4'hF);
    finish_acc(1'b0, 1'b0);
    rmem[17] = 16'h5566; smem[17] <= 16'h5566;
    issue(1'b0, 32'h0400_0020, 32'h00EE_0000, 4'b0100);
    finish_acc(1'b0, 1'b0);
    chk("rmw_hi_half", 32'(smem[17]), 32'h55EE);
    chk("rmw_lo_half", 32'(smem[16]), 32'hF00D);
    force_busy = 1'b1;
    issue(1'b0, 32'h0400_0030, 32'h0, 4'h0);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (re0 || we0) n++;
    end
    chk("busy_hold_enables", 32'(n), 32'h0);
    chk("busy_hold_bridge_busy", 32'(bb0), 32'h1);
    force_busy = 1'b0;
    finish_acc(1'b0, 1'b0);
    issue(1'b0, 32'h0400_0044, 32'h1357_9BDF, 4'b1001);
    finish_acc(1'b0, 1'b1);
    sel = 1'b1;
    no_resp = 1'b1;
    lat = 3;
    eops.push_back('{1'b0, 32, 16'h0});
    ersp.push_back('{32'hDEAD_BEEF, 1'b1, 1'b1});
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h0400_0040, 32'h0, 4'h0);
    finish_acc(1'b1, 1'b0);
    chk("timeout_then_idle", 32'(bb1), 32'h0);
    no_resp = 1'b0;
    issue(1'b1, 32'h0400_0040, 32'h0, 4'h0);
    finish_acc(1'b1, 1'b0);
    sel = 1'b0;
    lat = 40;
    issue(1'b0, 32'h0400_0050, 32'h0, 4'h0);
    n = 0;
    while (!re0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_rd_issued", 32'(re0), 32'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bridge_busy", 32'(bb0), 32'h0);
    chk("async_rst_rd_enable", 32'(re0), 32'h0);
    chk("async_rst_rd_addr", 32'(ra0), 32'h0);
    chk("async_rst_mem_ready", 32'(b0.mem_ready), 32'h0);
    eops.delete();
    ersp.delete();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 2;
    issue(1'b0, 32'h0400_0050, 32'h0, 4'h0);
    finish_acc(1'b0, 1'b0);
    repeat (40) begin
      ws = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
      lat = $urandom_range(1, 5);
      issue(1'b0, 32'h0400_0000 | 32'($urandom_range(0, 31) << 2), $urandom, ws);
      finish_acc(1'b0, $urandom_range(0, 3) == 0);
    end
    repeat (5) @(negedge clk);
    chk("ops_left", 32'(eops.size()), 32'h0);
    chk("rsp_left", 32'(ersp.size()), 32'h0);
    report();
  end
endmodule
